// File: rtl/oka_seq_mul.sv
// Sequential Karatsuba-style GF(2) polynomial multiplier: even/odd operand split,
// three half-width sub-products on one shared digit-serial engine, then recombination.
module oka_seq_mul #(
   parameter int N   = 142,
   parameter int DIG = 8
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [N-1:0]   a,
   input  logic [N-1:0]   b,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [2*N-2:0] y,
   output logic           busy
);

   localparam int H  = N / 2;
   localparam int K  = (H + DIG - 1) / DIG;
   localparam int KW = (K > 1) ? $clog2(K) : 1;
   localparam int AW = 2 * H - 1;
   localparam int YW = K * DIG;

   typedef enum logic [1:0] {IDLE, RUN, COMB, OUT} state_t;

   state_t         state, state_nx;
   logic [N-1:0]   a_r, b_r;
   logic [1:0]     phase;
   logic [KW-1:0]  digit;
   logic [AW-1:0]  acc, c0, c1, acc_step;
   logic [H-1:0]   ae, ao, be, bo, x_op, y_op;
   logic [YW-1:0]  y_pad;
   logic [DIG-1:0] dig_bits;
   logic [2*N-2:0] y_nx;
   logic           last_digit;

   // acc ^= (x * d) << (DIG*k); bits past AW can only come from zero padding
   function automatic logic [AW-1:0] mac(input logic [AW-1:0] acc_in, input logic [H-1:0] x,
                                         input logic [DIG-1:0] d, input logic [KW-1:0] k);
      logic [AW-1:0] r, xs;
      r  = acc_in;
      xs = AW'(x) << (DIG * int'(k));
      for (int j = 0; j < DIG; j++)
         if (d[j]) r = r ^ (xs << j);
      return r;
   endfunction

   always_comb begin
      for (int i = 0; i < H; i++) begin
         ae[i] = a_r[2*i];
         ao[i] = a_r[2*i+1];
         be[i] = b_r[2*i];
         bo[i] = b_r[2*i+1];
      end
   end

   always_comb begin
      x_op = ae ^ ao;
      y_op = be ^ bo;
      case (phase)
         2'd0: begin x_op = ae; y_op = be; end
         2'd1: begin x_op = ao; y_op = bo; end
         default: ;
      endcase
   end

   assign y_pad      = YW'(y_op);
   assign dig_bits   = DIG'(y_pad >> (DIG * int'(digit)));
   assign acc_step   = mac(acc, x_op, dig_bits, digit);
   assign last_digit = (digit == KW'(K - 1));

   // acc holds C2 once RUN finishes; c0x/c1x align C0[i] and C1[i-1] on even output bits
   always_comb begin
      logic [N-1:0]  c0x, c1x;
      logic [AW-1:0] m;
      c0x  = {1'b0, c0};
      c1x  = {c1, 1'b0};
      m    = acc ^ c0 ^ c1;
      y_nx = '0;
      for (int i = 0; i < N; i++)
         y_nx[2*i] = c0x[i] ^ c1x[i];
      for (int i = 0; i < N - 1; i++)
         y_nx[2*i+1] = m[i];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: if (in_valid) state_nx = RUN;
         RUN:  if (last_digit && phase == 2'd2) state_nx = COMB;
         COMB: state_nx = OUT;
         OUT:  if (out_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   assign in_ready = (state == IDLE);
   assign busy     = (state != IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_r       <= '0;
         b_r       <= '0;
         acc       <= '0;
         c0        <= '0;
         c1        <= '0;
         phase     <= '0;
         digit     <= '0;
         y         <= '0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= (state == COMB) || (state == OUT && !out_ready);
         case (state)
            IDLE: if (in_valid) begin
               a_r   <= a;
               b_r   <= b;
               acc   <= '0;
               phase <= '0;
               digit <= '0;
            end
            RUN: begin
               if (last_digit) begin
                  digit <= '0;
                  phase <= phase + 2'd1;
                  case (phase)
                     2'd0:    begin c0 <= acc_step; acc <= '0; end
                     2'd1:    begin c1 <= acc_step; acc <= '0; end
                     default: acc <= acc_step;
                  endcase
               end else begin
                  digit <= digit + KW'(1);
                  acc   <= acc_step;
               end
            end
            COMB: y <= y_nx;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_oka_seq_mul.sv
// Randomized bench for oka_seq_mul: N=142 at DIG=8 and DIG=5 side by side, plus two N=4
// instances, all checked against a plain shift-and-xor carry-less product.
module tb_oka_seq_mul;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [141:0] a, b;
   logic         in_valid, out_ready;
   logic         in_ready8, out_valid8, busy8, in_ready5, out_valid5, busy5;
   logic [282:0] y8, y5;

   logic [3:0]   a4, b4;
   logic         in_valid4, out_ready4;
   logic         in_ready4a, out_valid4a, busy4a, in_ready4b, out_valid4b, busy4b;
   logic [6:0]   y4a, y4b;

   int n_vec = 0;
   int n_bad = 0;

   oka_seq_mul #(.N(142), .DIG(8)) u8 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready8), .a(a), .b(b),
      .out_valid(out_valid8), .out_ready(out_ready), .y(y8), .busy(busy8));

   oka_seq_mul #(.N(142), .DIG(5)) u5 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready5), .a(a), .b(b),
      .out_valid(out_valid5), .out_ready(out_ready), .y(y5), .busy(busy5));

   oka_seq_mul #(.N(4), .DIG(2)) u4a (
      .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4a), .a(a4), .b(b4),
      .out_valid(out_valid4a), .out_ready(out_ready4), .y(y4a), .busy(busy4a));

   oka_seq_mul #(.N(4), .DIG(1)) u4b (
      .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4b), .a(a4), .b(b4),
      .out_valid(out_valid4b), .out_ready(out_ready4), .y(y4b), .busy(busy4b));

   task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [283:0] clmul(input logic [141:0] x, input logic [141:0] z);
      logic [283:0] r;
      r = '0;
      for (int i = 0; i < 142; i++)
         if (x[i]) r = r ^ (284'(z) << i);
      return r;
   endfunction

   function automatic logic [141:0] rnd();
      logic [141:0] r;
      for (int i = 0; i < 142; i++) r[i] = 1'($urandom);
      return r;
   endfunction

   // Accept one pair on both N=142 instances, scramble inputs while busy, then release.
   task automatic run_big(input logic [141:0] aa, input logic [141:0] bb,
                          input logic [283:0] exp, input int hold);
      int cyc, l8, l5;
      @(negedge clk);
      a = aa; b = bb; in_valid = 1'b1;
      @(posedge clk); #1;
      cyc = 0; l8 = -1; l5 = -1;
      while ((l8 < 0 || l5 < 0) && cyc < 100) begin
         a = rnd(); b = rnd(); in_valid = 1'($urandom);
         @(posedge clk); #1;
         cyc++;
         if (out_valid8 && l8 < 0) l8 = cyc;
         if (out_valid5 && l5 < 0) l5 = cyc;
      end
      in_valid = 1'b0;
      chk("lat_dig8", 512'(l8), 512'(28));
      chk("lat_dig5", 512'(l5), 512'(46));
      chk("y_dig8", 512'(y8), 512'(exp[282:0]));
      chk("y_dig5", 512'(y5), 512'(exp[282:0]));
      for (int h = 0; h < hold; h++) begin
         in_valid = 1'($urandom); a = rnd(); b = rnd();
         @(posedge clk); #1;
         chk("hold_y", 512'(y8), 512'(exp[282:0]));
         chk("hold_valid", 512'(out_valid8), 512'(1));
         chk("hold_in_ready", 512'(in_ready8), 512'(0));
      end
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("release_valid", 512'(out_valid8 | out_valid5), 512'(0));
      chk("release_ready", 512'({in_ready8, in_ready5}), 512'(2'b11));
   endtask

   task automatic run_small(input logic [3:0] aa, input logic [3:0] bb, input logic [6:0] exp);
      int cyc, la, lb;
      @(negedge clk);
      a4 = aa; b4 = bb; in_valid4 = 1'b1;
      @(posedge clk); #1;
      in_valid4 = 1'b0;
      cyc = 0; la = -1; lb = -1;
      while ((la < 0 || lb < 0) && cyc < 30) begin
         a4 = 4'($urandom); b4 = 4'($urandom);
         @(posedge clk); #1;
         cyc++;
         if (out_valid4a && la < 0) la = cyc;
         if (out_valid4b && lb < 0) lb = cyc;
      end
      chk("lat4_dig2", 512'(la), 512'(4));
      chk("lat4_dig1", 512'(lb), 512'(7));
      chk("y4_dig2", 512'(y4a), 512'(exp));
      chk("y4_dig1", 512'(y4b), 512'(exp));
      @(negedge clk);
      out_ready4 = 1'b1;
      @(posedge clk); #1;
      out_ready4 = 1'b0;
   endtask

   initial begin
      logic [141:0] ta, tb;
      logic [283:0] ev;
      int rises;
      rst = 1'b1;
      a = '0; b = '0; in_valid = 1'b0; out_ready = 1'b0;
      a4 = '0; b4 = '0; in_valid4 = 1'b0; out_ready4 = 1'b0;
      #12;
      chk("rst_in_ready", 512'(in_ready8), 512'(1));
      chk("rst_out_valid", 512'(out_valid8), 512'(0));
      chk("rst_busy", 512'(busy8), 512'(0));
      chk("rst_y", 512'(y8), 512'(0));
      @(negedge clk);
      rst = 1'b0;

      run_small(4'b0011, 4'b0011, 7'b0000101);
      run_small(4'b1111, 4'b1111, 7'b1010101);
      for (int i = 0; i < 20; i++) begin
         ta = 142'($urandom_range(0, 15));
         tb = 142'($urandom_range(0, 15));
         ev = clmul(ta, tb);
         run_small(ta[3:0], tb[3:0], ev[6:0]);
      end

      tb = rnd();
      run_big(142'd1, tb, 284'(tb), 0);
      run_big(142'd1 << 141, 142'd1 << 141, 284'd1 << 282, 0);
      ev = '0;
      for (int i = 0; i < 142; i++) ev[2*i] = 1'b1;
      run_big({142{1'b1}}, {142{1'b1}}, ev, 0);
      run_big('0, rnd(), '0, 0);

      ta = rnd(); tb = rnd();
      run_big(ta, tb, clmul(ta, tb), 20);

      // abort in phase 1 of the DIG=8 instance
      @(negedge clk);
      a = rnd(); b = rnd(); in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (12) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("abort_out_valid", 512'(out_valid8), 512'(0));
      chk("abort_busy", 512'(busy8), 512'(0));
      chk("abort_in_ready", 512'(in_ready8), 512'(1));
      chk("abort_y", 512'(y8), 512'(0));
      @(negedge clk);
      rst = 1'b0;
      rises = 0;
      repeat (50) begin
         @(posedge clk); #1;
         if (out_valid8 || out_valid5) rises++;
      end
      chk("abort_no_valid", 512'(rises), 512'(0));
      ta = rnd(); tb = rnd();
      run_big(ta, tb, clmul(ta, tb), 0);

      for (int i = 0; i < 700; i++) begin
         ta = rnd(); tb = rnd();
         case ($urandom_range(0, 3))
            0: ta = ta & rnd() & rnd();
            1: tb = tb | rnd();
            default: ;
         endcase
         run_big(ta, tb, clmul(ta, tb), 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
